fifo_rd_stream: RTL

- Read-side drain engine for the NoP async FIFO. Sits in the read clock domain and pops flits through the FIFO read port (rd_en / empty / rd_data).
- Hides the one-cycle RAM read latency and re-presents the flits as a registered valid/ready stream to the downstream router input port.
- A small local skid buffer sustains one flit per cycle while downstream backpressure is absorbed without loss.

---
 rtl/fifo_rd_stream_if.sv | 24 ++
 rtl/fifo_rd_stream.sv | 81 ++++++++
 2 files changed

// File: rtl/fifo_rd_stream_if.sv
// Read-side bundle of fifo_rd_stream: the FIFO read port together with the
// registered valid/ready stream presented to the downstream router port.
interface fifo_rd_stream_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_rd_data;
   logic                  fifo_rd_en;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_ready;

   // Drain engine side: pops the FIFO and drives the stream.
   modport master (
      input  fifo_empty, fifo_rd_data, out_ready,
      output fifo_rd_en, out_valid, out_data
   );

   // FIFO and downstream router side.
   modport slave (
      output fifo_empty, fifo_rd_data, out_ready,
      input  fifo_rd_en, out_valid, out_data
   );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side drain engine for the NoP async FIFO. Pops flits, hides the
// one-cycle RAM read latency and re-presents them as a registered valid/ready
// stream through a small skid buffer, so backpressure never loses a flit.
module fifo_rd_stream #(
   parameter int DATA_WIDTH = 16,
   parameter int BUF_AW     = 2,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 rdclk,
   input  logic                 rstn_rdclk,
   fifo_rd_stream_if.master     rd_if,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] flit_cnt
);
   localparam int PW        = BUF_AW + 1;
   localparam int BUF_DEPTH = 2 ** BUF_AW;
   localparam logic [PW-1:0] FULL_OCC  = PW'(BUF_DEPTH);
   localparam logic [PW:0]   DEPTH_RES = (PW + 1)'(BUF_DEPTH);

   logic [PW-1:0]         wptr;
   logic [PW-1:0]         rptr;
   logic [PW-1:0]         occ;
   logic [PW:0]           reserved;
   logic                  inflight;
   logic                  hs;
   logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];

   // Occupancy is the modular pointer distance; the extra pointer bit tells
   // full (BUF_DEPTH) apart from empty (0).
   assign occ      = wptr - rptr;
   assign reserved = {1'b0, occ} + {{PW{1'b0}}, inflight};

   // Issue only from registered state plus the empty flag, counting the
   // in-flight slot so a returning flit always finds room. Gating with the
   // reset keeps the pop request low while the block is held in reset.
   assign rd_if.fifo_rd_en = rstn_rdclk & ~rd_if.fifo_empty & (reserved < DEPTH_RES);

   assign rd_if.out_valid = (occ != '0);
   assign rd_if.out_data  = buf_mem[rptr[BUF_AW-1:0]];
   assign hs              = rd_if.out_valid & rd_if.out_ready;
   assign busy            = rd_if.out_valid | inflight;

   // Pop tracking, buffer pointers and delivered-flit counter.
   always_ff @(posedge rdclk or negedge rstn_rdclk) begin
      if (!rstn_rdclk) begin
         inflight <= 1'b0;
         wptr     <= '0;
         rptr     <= '0;
         flit_cnt <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register here sees the
         // pre-edge values of the others, whatever the statement order.
         inflight <= rd_if.fifo_rd_en;
         if (inflight) begin
            wptr <= wptr + PW'(1);
         end
         if (hs) begin
            rptr     <= rptr + PW'(1);
            flit_cnt <= flit_cnt + CNT_WIDTH'(1);
         end
      end
   end

   // Skid storage: capture the RAM data the cycle after each pop.
   always_ff @(posedge rdclk or negedge rstn_rdclk) begin
      if (!rstn_rdclk) begin
         // NOTE: the entries are reset so out_data reads 0 out of reset
         // without needing an extra output gate on out_valid.
         for (int i = 0; i < BUF_DEPTH; i++) begin
            buf_mem[i] <= '0;
         end
      end else if (inflight) begin
         buf_mem[wptr[BUF_AW-1:0]] <= rd_if.fifo_rd_data;
      end
   end

   // A capture must always find a free slot; the issue rule reserves it.
   a_no_overflow: assert property (@(posedge rdclk) disable iff (!rstn_rdclk)
      !(inflight && (occ == FULL_OCC)));

endmodule
